// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - memory-op codes, FSM states and store-lane helpers
package mem_access_unit_pkg;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_SB   = 4'b0001;
  localparam logic [3:0] OP_SH   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_LB   = 4'b1000;
  localparam logic [3:0] OP_LH   = 4'b1001;
  localparam logic [3:0] OP_LW   = 4'b1010;
  localparam logic [3:0] OP_LBU  = 4'b1100;
  localparam logic [3:0] OP_LHU  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_SH, OP_LH, OP_LHU: return off[0];
      OP_SW, OP_LW:         return |off;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_byte_en(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_SB:   return 4'b0001 << off;
      OP_SH:   return 4'b0011 << {off[1], 1'b0};
      OP_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicating the narrow value lets the byte enables alone select the lane.
  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] data);
    case (op)
      OP_SB:   return {4{data[7:0]}};
      OP_SH:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - word-wide data-memory port
interface mem_access_unit_if;

  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [29:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport master (
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTE_EN,
    input  MEM_READDATA, MEM_BUSYWAIT
  );

  modport slave (
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTE_EN,
    output MEM_READDATA, MEM_BUSYWAIT
  );

endinterface

// File: rtl/mem_access_unit_load_data_extender.sv
// rtl/mem_access_unit_load_data_extender.sv - selects the loaded byte/half/word and extends it
module load_data_extender
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] readdata,
  input  logic [1:0]  addr,
  input  logic [3:0]  op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = readdata[{addr, 3'b000} +: 8];
  assign half_sel = readdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    result = 32'd0;
    case (op)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'd0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'd0, half_sel};
      OP_LW:   result = readdata;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage responder: aligns stores, extends loads, stalls the pipeline
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [3:0]         IN_READ_WRITE,
  input  logic [31:0]        IN_ALU_RESULT,
  input  logic [31:0]        IN_DATA2,
  output logic               BUSYWAIT,
  output logic [31:0]        OUT_READ_DATA,
  output logic               OUT_MISALIGNED,
  output logic               OUT_MEM_ERROR,
  mem_access_unit_if.master  mem
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       op_q;
  logic [1:0]       off_q;
  logic             valid_op;
  logic             misaligned;
  logic [31:0]      load_result;

  assign valid_op   = op_is_load(IN_READ_WRITE) || op_is_store(IN_READ_WRITE);
  assign misaligned = valid_op && op_misaligned(IN_READ_WRITE, IN_ALU_RESULT[1:0]);

  assign OUT_MISALIGNED = (state == ST_IDLE) && misaligned;
  assign BUSYWAIT       = ((state == ST_IDLE) && valid_op && !misaligned) ||
                          (state == ST_ACCESS);

  // Extraction works from the op/offset captured at issue, not the live pipeline inputs.
  load_data_extender u_extender (
    .readdata (mem.MEM_READDATA),
    .addr     (off_q),
    .op       (op_q),
    .result   (load_result)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state             <= ST_IDLE;
      wait_cnt          <= '0;
      op_q              <= OP_NONE;
      off_q             <= 2'd0;
      mem.MEM_READ      <= 1'b0;
      mem.MEM_WRITE     <= 1'b0;
      mem.MEM_ADDRESS   <= 30'd0;
      mem.MEM_WRITEDATA <= 32'd0;
      mem.MEM_BYTE_EN   <= 4'd0;
      OUT_READ_DATA     <= 32'd0;
      OUT_MEM_ERROR     <= 1'b0;
    end else begin
      OUT_MEM_ERROR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_op && !misaligned) begin
            mem.MEM_READ      <= op_is_load(IN_READ_WRITE);
            mem.MEM_WRITE     <= op_is_store(IN_READ_WRITE);
            mem.MEM_ADDRESS   <= IN_ALU_RESULT[31:2];
            mem.MEM_BYTE_EN   <= store_byte_en(IN_READ_WRITE, IN_ALU_RESULT[1:0]);
            mem.MEM_WRITEDATA <= store_data(IN_READ_WRITE, IN_DATA2);
            op_q              <= IN_READ_WRITE;
            off_q             <= IN_ALU_RESULT[1:0];
            wait_cnt          <= '0;
            state             <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!mem.MEM_BUSYWAIT) begin
            mem.MEM_READ  <= 1'b0;
            mem.MEM_WRITE <= 1'b0;
            if (op_is_load(op_q)) begin
              OUT_READ_DATA <= load_result;
            end
            state <= ST_DONE;
          end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
            mem.MEM_READ  <= 1'b0;
            mem.MEM_WRITE <= 1'b0;
            OUT_MEM_ERROR <= 1'b1;
            OUT_READ_DATA <= 32'd0;
            state         <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        // One non-stalled cycle lets the pipeline move past the op so it is not re-issued.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TO = 4;
  localparam logic [3:0] C_NONE = 4'b0000, C_SB = 4'b0001, C_SH = 4'b0010, C_SW = 4'b0011;
  localparam logic [3:0] C_LB = 4'b1000, C_LH = 4'b1001, C_LW = 4'b1010;
  localparam logic [3:0] C_LBU = 4'b1100, C_LHU = 4'b1101;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  IN_READ_WRITE;
  logic [31:0] IN_ALU_RESULT;
  logic [31:0] IN_DATA2;
  logic        BUSYWAIT;
  logic [31:0] OUT_READ_DATA;
  logic        OUT_MISALIGNED;
  logic        OUT_MEM_ERROR;

  mem_access_unit_if mem_if ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .IN_READ_WRITE  (IN_READ_WRITE),
    .IN_ALU_RESULT  (IN_ALU_RESULT),
    .IN_DATA2       (IN_DATA2),
    .BUSYWAIT       (BUSYWAIT),
    .OUT_READ_DATA  (OUT_READ_DATA),
    .OUT_MISALIGNED (OUT_MISALIGNED),
    .OUT_MEM_ERROR  (OUT_MEM_ERROR),
    .mem            (mem_if)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Per-cycle expectations written by the driver, checked on the falling edge.
  logic        chk_en = 1'b0;
  logic        e_bw, e_mis, e_rd_strb, e_wr_strb, e_err;
  logic [29:0] e_addr;
  logic [3:0]  e_be;
  logic [31:0] e_wdata, e_rdata, rd_hold;
  int          bw_cnt, rd_cnt, wr_cnt, err_cnt;
  logic [29:0] last_addr;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("BUSYWAIT", 32'(BUSYWAIT), 32'(e_bw));
      chk("OUT_MISALIGNED", 32'(OUT_MISALIGNED), 32'(e_mis));
      chk("MEM_READ", 32'(mem_if.MEM_READ), 32'(e_rd_strb));
      chk("MEM_WRITE", 32'(mem_if.MEM_WRITE), 32'(e_wr_strb));
      chk("OUT_MEM_ERROR", 32'(OUT_MEM_ERROR), 32'(e_err));
      chk("OUT_READ_DATA", OUT_READ_DATA, e_rdata);
      if (e_rd_strb || e_wr_strb) begin
        chk("MEM_ADDRESS", 32'(mem_if.MEM_ADDRESS), 32'(e_addr));
        chk("MEM_BYTE_EN", 32'(mem_if.MEM_BYTE_EN), 32'(e_be));
      end
      if (e_wr_strb) chk("MEM_WRITEDATA", mem_if.MEM_WRITEDATA, e_wdata);
      if (BUSYWAIT) bw_cnt++;
      if (mem_if.MEM_READ) rd_cnt++;
      if (OUT_MEM_ERROR) err_cnt++;
      if (mem_if.MEM_READ || mem_if.MEM_WRITE) begin
        last_addr = mem_if.MEM_ADDRESS;
        last_be   = mem_if.MEM_BYTE_EN;
      end
      if (mem_if.MEM_WRITE) begin
        wr_cnt++;
        last_wdata = mem_if.MEM_WRITEDATA;
      end
    end
  end

  task automatic clr_cnt();
    bw_cnt = 0; rd_cnt = 0; wr_cnt = 0; err_cnt = 0;
  endtask

  function automatic logic [31:0] load_val(input logic [3:0] op, input int off, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'h0000_00FF;
    h = (rd >> (16 * (off / 2))) & 32'h0000_FFFF;
    case (op)
      C_LB:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      C_LBU:   return b;
      C_LH:    return h[15] ? (h | 32'hFFFF_0000) : h;
      C_LHU:   return h;
      default: return rd;
    endcase
  endfunction

  // Entered just after a rising edge with the DUT idle; returns just after the edge ending the op.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdata, input int waits);
    int off, n_acc, total;
    bit is_ld, is_st, mis, go, tmo, acc, done;
    off   = int'(addr[1:0]);
    is_ld = (op == C_LB) || (op == C_LH) || (op == C_LW) || (op == C_LBU) || (op == C_LHU);
    is_st = (op == C_SB) || (op == C_SH) || (op == C_SW);
    mis   = ((op == C_LH || op == C_LHU || op == C_SH) && (off % 2 != 0)) ||
            ((op == C_LW || op == C_SW) && (off != 0));
    go    = (is_ld || is_st) && !mis;
    tmo   = (waits >= TO);
    n_acc = tmo ? TO : waits + 1;
    total = go ? n_acc + 2 : 1;
    e_addr  = addr[31:2];
    e_be    = (op == C_SB) ? 4'(1 << off) : (op == C_SH) ? 4'(3 << (off & 2)) :
              (op == C_SW) ? 4'hF : 4'h0;
    e_wdata = (op == C_SB) ? 32'(data[7:0]) * 32'h0101_0101 :
              (op == C_SH) ? 32'(data[15:0]) * 32'h0001_0001 : data;
    for (int c = 0; c < total; c++) begin
      acc  = go && (c >= 1) && (c <= n_acc);
      done = go && (c == n_acc + 1);
      IN_READ_WRITE        = op;
      IN_ALU_RESULT        = addr;
      IN_DATA2             = data;
      mem_if.MEM_READDATA  = rdata;
      mem_if.MEM_BUSYWAIT  = acc && (c - 1 < waits);
      e_bw      = go && (c <= n_acc);
      e_mis     = (c == 0) && mis;
      e_rd_strb = acc && is_ld;
      e_wr_strb = acc && is_st;
      e_err     = done && tmo;
      if (done && tmo) rd_hold = 32'd0;
      else if (done && is_ld) rd_hold = load_val(op, off, rdata);
      e_rdata = rd_hold;
      chk_en  = 1'b1;
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0;
    IN_READ_WRITE = C_NONE; IN_ALU_RESULT = 32'd0; IN_DATA2 = 32'd0;
    mem_if.MEM_READDATA = 32'd0; mem_if.MEM_BUSYWAIT = 1'b0;
    rd_hold = 32'd0;
    clr_cnt();

    @(negedge CLK);
    chk("reset BUSYWAIT", 32'(BUSYWAIT), 32'd0);
    chk("reset MEM_READ", 32'(mem_if.MEM_READ), 32'd0);
    chk("reset MEM_WRITE", 32'(mem_if.MEM_WRITE), 32'd0);
    chk("reset MEM_ADDRESS", 32'(mem_if.MEM_ADDRESS), 32'd0);
    chk("reset MEM_BYTE_EN", 32'(mem_if.MEM_BYTE_EN), 32'd0);
    chk("reset MEM_WRITEDATA", mem_if.MEM_WRITEDATA, 32'd0);
    chk("reset OUT_READ_DATA", OUT_READ_DATA, 32'd0);
    chk("reset OUT_MEM_ERROR", 32'(OUT_MEM_ERROR), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;

    // Stores with a zero-wait memory.
    clr_cnt();
    run_op(C_SW, 32'h0000_0104, 32'hDEAD_BEEF, 32'd0, 0);
    chk("sw busy cycles", 32'(bw_cnt), 32'd2);
    chk("sw write strobes", 32'(wr_cnt), 32'd1);
    chk("sw address", 32'(last_addr), 32'h41);
    chk("sw byte_en", 32'(last_be), 32'hF);
    chk("sw writedata", last_wdata, 32'hDEAD_BEEF);
    run_op(C_SB, 32'h0000_0103, 32'h0000_00A5, 32'd0, 0);
    chk("sb byte_en", 32'(last_be), 32'h8);
    chk("sb writedata", last_wdata, 32'hA5A5_A5A5);
    run_op(C_SH, 32'h0000_0102, 32'h0000_1234, 32'd0, 0);
    chk("sh byte_en", 32'(last_be), 32'hC);
    chk("sh writedata", last_wdata, 32'h1234_1234);

    // Loads against a 3-wait memory.
    clr_cnt();
    run_op(C_LB, 32'h0000_0203, 32'd0, 32'h80F1_7F00, 3);
    chk("lb busy cycles", 32'(bw_cnt), 32'd5);
    chk("lb result", OUT_READ_DATA, 32'hFFFF_FF80);
    clr_cnt();
    run_op(C_LBU, 32'h0000_0203, 32'd0, 32'h80F1_7F00, 3);
    chk("lbu busy cycles", 32'(bw_cnt), 32'd5);
    chk("lbu result", OUT_READ_DATA, 32'h0000_0080);
    run_op(C_LH, 32'h0000_0202, 32'd0, 32'h80F1_7F00, 3);
    chk("lh result", OUT_READ_DATA, 32'hFFFF_80F1);
    run_op(C_LHU, 32'h0000_0202, 32'd0, 32'h80F1_7F00, 3);
    chk("lhu result", OUT_READ_DATA, 32'h0000_80F1);
    run_op(C_LW, 32'h0000_0200, 32'd0, 32'h80F1_7F00, 3);
    chk("lw result", OUT_READ_DATA, 32'h80F1_7F00);
    run_op(C_SB, 32'h0000_0200, 32'h0000_0011, 32'hFFFF_FFFF, 1);
    chk("store keeps read data", OUT_READ_DATA, 32'h80F1_7F00);

    // Non-memory and misaligned ops make no access.
    clr_cnt();
    run_op(C_NONE, 32'h0000_0100, 32'd0, 32'd0, 0);
    run_op(4'b0111, 32'h0000_0100, 32'd0, 32'd0, 0);
    run_op(C_LW, 32'h0000_0102, 32'd0, 32'd0, 0);
    run_op(C_LH, 32'h0000_0101, 32'd0, 32'd0, 0);
    run_op(C_SW, 32'h0000_0101, 32'd0, 32'd0, 0);
    chk("no-access busy cycles", 32'(bw_cnt), 32'd0);
    chk("no-access strobes", 32'(rd_cnt + wr_cnt), 32'd0);
    clr_cnt();
    run_op(C_LB, 32'h0000_0101, 32'd0, 32'h0000_AB00, 0);
    chk("lb odd read strobes", 32'(rd_cnt), 32'd1);
    chk("lb odd result", OUT_READ_DATA, 32'hFFFF_FFAB);

    // Memory stuck busy: abort after TO wait cycles.
    clr_cnt();
    run_op(C_LW, 32'h0000_0300, 32'd0, 32'h1234_5678, 100);
    chk("timeout error pulses", 32'(err_cnt), 32'd1);
    chk("timeout strobe cycles", 32'(rd_cnt), 32'd4);
    chk("timeout result", OUT_READ_DATA, 32'd0);
    run_op(C_LW, 32'h0000_0300, 32'd0, 32'h1234_5678, 3);
    chk("post-timeout lw result", OUT_READ_DATA, 32'h1234_5678);

    // Asynchronous reset in the middle of an access.
    chk_en = 1'b0;
    IN_READ_WRITE = C_LW; IN_ALU_RESULT = 32'h0000_0200;
    mem_if.MEM_BUSYWAIT = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #3;
    chk("pre-reset read strobe", 32'(mem_if.MEM_READ), 32'd1);
    RESET = 1'b0; IN_READ_WRITE = C_NONE; mem_if.MEM_BUSYWAIT = 1'b0;
    #1;
    chk("async reset MEM_READ", 32'(mem_if.MEM_READ), 32'd0);
    chk("async reset BUSYWAIT", 32'(BUSYWAIT), 32'd0);
    chk("async reset OUT_READ_DATA", OUT_READ_DATA, 32'd0);
    rd_hold = 32'd0;
    @(posedge CLK); #2;
    RESET = 1'b1;
    @(posedge CLK); #1;
    clr_cnt();
    run_op(C_LW, 32'h0000_0200, 32'd0, 32'hCAFE_F00D, 0);
    run_op(C_SW, 32'h0000_0204, 32'h1122_3344, 32'd0, 0);
    chk("post-reset read strobes", 32'(rd_cnt), 32'd1);
    chk("post-reset write strobes", 32'(wr_cnt), 32'd1);
    chk("post-reset lw result", OUT_READ_DATA, 32'hCAFE_F00D);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage responder for the EX/MEM pipeline register. It consumes the register's memory-op fields and drives the word-wide data-memory port.
- Performs store byte-lane alignment, load extraction with sign/zero extension, and misalignment detection.
- Drives BUSYWAIT back to all pipeline registers so they hold while an access is in flight.
- The load result feeds the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles in ACCESS before abort; 0 disables the timeout.
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
CLK  in  1  clock; all state changes on rising edge.
RESET  in  1  asynchronous, active-low reset.
IN_READ_WRITE  in  4  memory-op code from EX/MEM (encoding below).
IN_ALU_RESULT  in  32  byte address.
IN_DATA2  in  32  store data (rs2).
BUSYWAIT  out  1  pipeline stall request.
OUT_READ_DATA  out  32  extended load result.
OUT_MISALIGNED  out  1  current op is misaligned; no access is made.
OUT_MEM_ERROR  out  1  one-cycle pulse when an access times out.
MEM_READ  out  1  memory read strobe (registered).
MEM_WRITE  out  1  memory write strobe (registered).
MEM_ADDRESS  out  30  word address, IN_ALU_RESULT[31:2] (registered).
MEM_WRITEDATA  out  32  lane-aligned store data (registered).
MEM_BYTE_EN  out  4  byte-lane enables (registered).
MEM_READDATA  in  32  memory read word.
MEM_BUSYWAIT  in  1  memory not ready.

Behaviour:
- Op encoding:
  - NONE 0000.
  - Stores: SB 0001, SH 0010, SW 0011.
  - Loads: LB 1000, LH 1001, LW 1010, LBU 1100, LHU 1101.
  - Any other code is treated as NONE.
- Reset (RESET=0, asynchronous):
  - State goes to IDLE.
  - MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTE_EN, OUT_READ_DATA, OUT_MEM_ERROR and the wait counter all go to 0.
  - Reset mid-access aborts the access; the strobes drop immediately.
- Misaligned condition (combinational): LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - OUT_MISALIGNED=1 while such an op is presented in IDLE.
  - No memory access is made and no stall is raised.
- BUSYWAIT (combinational) = (IDLE and valid op and not misaligned) or ACCESS. It is 0 in DONE and for NONE ops.
- FSM:
  - IDLE:
    - On a valid aligned op, register the strobe, address, byte enables and write data, clear the counter, and go to ACCESS at the next edge.
    - Otherwise stay in IDLE.
  - ACCESS:
    - Strobe held.
    - Edge with MEM_BUSYWAIT=0: drop the strobes. For a load, register the extended result into OUT_READ_DATA. Go to DONE.
    - Edge with MEM_BUSYWAIT=1: increment the counter.
    - When the counter reaches TIMEOUT_CYCLES (nonzero): drop the strobes, pulse OUT_MEM_ERROR for one cycle, force OUT_READ_DATA=0, go to DONE.
  - DONE:
    - BUSYWAIT=0, so the pipeline advances at this edge. Unconditional transition to IDLE.
    - This guarantees the held op is not re-issued.
- Latency:
  - With a zero-wait memory, an op occupies 3 cycles: IDLE (stall), ACCESS, DONE.
  - Each memory wait cycle adds 1 cycle.
  - Non-memory ops add 0 cycles.
- Store alignment:
  - SB: BYTE_EN = 0001 << addr[1:0]; data = byte replicated 4 times.
  - SH: BYTE_EN = 0011 << {addr[1],1'b0}; data = halfword replicated twice.
  - SW: BYTE_EN = 1111; data unchanged.
  - Loads: BYTE_EN = 0000.
- Load extraction:
  - Byte = READDATA[8*addr[1:0] +: 8].
  - Half = READDATA[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- OUT_READ_DATA holds its last value until the next load completes or a timeout occurs. Stores do not change it.

Decomposition:
- Shared include mem_ops.vh:
  - op-code constants (NONE, SB, SH, SW, LB, LH, LW, LBU, LHU);
  - FSM state encodings IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
- One combinational sub-module, load_data_extender: inputs readdata, addr[1:0], op; output 32-bit extended result.

Test Plan:
- Zero-wait memory, SW addr 0x104 data 0xDEADBEEF -> BUSYWAIT high for 2 cycles; MEM_WRITE one cycle with MEM_ADDRESS=0x41, BYTE_EN=1111; pipeline advances on cycle 3.
- SB addr 0x103 data 0x000000A5 -> BYTE_EN=1000, WRITEDATA=0xA5A5A5A5. SH addr 0x102 data 0x1234 -> BYTE_EN=1100, WRITEDATA=0x12341234.
- READDATA=0x80F17F00 at addr 0x200 with 3 memory wait cycles:
  - LB offset 3 -> 0xFFFFFF80; LBU offset 3 -> 0x00000080; LH offset 2 -> 0xFFFF80F1; LW -> 0x80F17F00.
  - Each op shows 5 BUSYWAIT cycles.
- LW addr 0x102 -> OUT_MISALIGNED=1, BUSYWAIT=0, no strobe. LH addr 0x101 -> same. LB addr 0x101 -> normal access.
- TIMEOUT_CYCLES=4 with MEM_BUSYWAIT stuck at 1 -> strobe drops after 4 wait cycles; OUT_MEM_ERROR pulses once; OUT_READ_DATA=0; FSM returns to IDLE via DONE.
- RESET driven low mid-ACCESS between clock edges -> MEM_READ=0 immediately, BUSYWAIT=0, state IDLE. After release, back-to-back LW/SW each complete exactly once.
